mux_pipe_stage: RTL and testbench
=================================

Name: mux_pipe_stage

Overview:
Registered, flow-controlled stage directly downstream of the 8-bit 2:1 operand mux. Performs the same selection as the mux: out = data_a when sel_a=1, data_b when sel_a=0. The selected word is captured into a 2-entry skid buffer with valid/ready handshakes on both sides. This lets the mux result cross into the registered datapath without combinational ready paths. It also keeps full throughput under back-pressure.

Parameters:
WIDTH, 8, data width of data_a, data_b and out.

Ports:
clk  input  1  rising-edge clock
rst_  input  1  synchronous reset, active-low
data_a  input  WIDTH  operand A, selected when sel_a=1
data_b  input  WIDTH  operand B, selected when sel_a=0
sel_a  input  1  select A
in_valid  input  1  upstream offers {data_a, data_b, sel_a}
in_ready  output  1  stage can accept; registered, no combinational path from out_ready
out  output  WIDTH  head-of-buffer selected word, driven from a register
out_valid  output  1  out holds a valid word
out_ready  input  1  downstream accepts out this cycle
level  output  2  occupancy, 0..2

Behaviour:
Interface and reset:
- One clock, clk. Reset rst_ is synchronous and active-low: sampled only on the rising edge of clk.
- While rst_=0 at a clock edge, all of the following hold after that edge:
  - out_valid=0, out='0, level=0, in_ready=1.
  - Both buffer entries are cleared and any held word is discarded.
- Reset asserted mid-transfer: contents are dropped with no partial output. The first accept after reset deasserts is the first word out.

Handshake:
- Input accept: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- Selection happens at accept time and only the selected WIDTH-bit word is stored. Later changes to sel_a or the data inputs do not affect stored words.
- States by occupancy:
  - EMPTY (level=0): in_ready=1, out_valid=0.
  - ONE (level=1): in_ready=1, out_valid=1, out=entry0.
  - FULL (level=2): in_ready=0, out_valid=1, out=entry0 (oldest), entry1 held.
- Transitions per edge:
  - EMPTY, accept → ONE. out valid one cycle after accept (latency 1).
  - ONE, accept & no transfer → FULL.
  - ONE, transfer & no accept → EMPTY.
  - ONE, accept & transfer → ONE, out = new word (full throughput, 1 word/cycle).
  - FULL, transfer → ONE, entry1 moves to entry0. No accept is possible because in_ready=0.
  - Otherwise hold. out and out_valid stay stable while out_valid=1 and out_ready=0.

Ordering and boundaries:
- Words leave in accept order; no drops, no duplicates.
- in_valid while in_ready=0 has no effect; upstream must hold its request.
- out_ready while out_valid=0 has no effect.
- X/Z on sel_a or data inputs while in_valid=0 must not corrupt state.

Test Plan:
- Reset: drive rst_=0 for 2 edges with in_valid=1 → out_valid=0, out=8'h00, level=0, in_ready=1. The first edge after rst_=1 accepts.
- Select truth: out_ready=1, accept {a=8'hFF, b=8'h00, sel_a=1} then {a=8'hFF, b=8'h00, sel_a=0} → out=8'hFF, then 8'h00 on the following cycles, each with latency 1.
- Streaming: out_ready=1, in_valid=1 every cycle with sel_a=1 and data_a=1,2,…,8 → out=1..8 on consecutive cycles, level stays 1, in_ready stays 1.
- Back-pressure: out_ready=0, accept 8'hA5 (sel_a=1) then 8'h5A (sel_a=0, data_b=8'h5A) → level=2, in_ready=0, out holds 8'hA5. A third offer is not accepted. Then out_ready=1 → outputs 8'hA5 then 8'h5A, and level returns to 0.
- Input change after capture: accept sel_a=1, data_a=8'h3C, then change data_a to 8'hC3 and sel_a to 0 with in_valid=0 while out_ready=0 → out stays 8'h3C.
- Mid-operation reset: FULL state with out_ready=0, assert rst_=0 for 1 edge → level=0, out_valid=0. Buffered words never appear on out.

Source files
------------

// File: rtl/mux_pipe_stage.sv
// Registered 2:1 operand select feeding a 2-entry skid buffer.
// Valid/ready on both sides; in_ready and out are pure register outputs.
module mux_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             sel_a,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       level
);

  // Handshake: a word moves on any rising edge where valid & ready are both 1;
  // a producer holding valid must keep its payload stable until accepted.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_entry0;
  logic [WIDTH-1:0] r_entry1;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_level;

  logic [WIDTH-1:0] w_sel;
  logic             w_accept;
  logic             w_xfer;

  assign w_sel    = sel_a ? data_a : data_b;
  assign w_accept = in_valid & r_in_ready;
  assign w_xfer   = r_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state     <= ST_EMPTY;
      r_entry0    <= '0;
      r_entry1    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_level     <= 2'd0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_entry0    <= w_sel;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_level     <= 2'd1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_xfer) begin
            r_entry0 <= w_sel;
          end else if (w_accept) begin
            r_entry1   <= w_sel;
            r_state    <= ST_FULL;
            r_in_ready <= 1'b0;
            r_level    <= 2'd2;
          end else if (w_xfer) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_level     <= 2'd0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain case exists.
          if (w_xfer) begin
            r_entry0   <= r_entry1;
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
            r_level    <= 2'd1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_level     <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out       = r_entry0;
  assign out_valid = r_out_valid;
  assign level     = r_level;

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Bench for mux_pipe_stage: directed steps then random traffic, all checked
// against a queue model of the buffer contents.
module tb_mux_pipe_stage;

  logic       clk;
  logic       rst_;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic       sel_a;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] level;

  logic [7:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  mux_pipe_stage #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .data_a    (data_a),
    .data_b    (data_b),
    .sel_a     (sel_a),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic check_state();
    chk("level", {30'd0, level}, exp_q.size());
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
    if (exp_q.size() > 0) chk("out", {24'd0, out}, {24'd0, exp_q[0]});
  endtask

  // One clock of stimulus; model updates with the values presented at the edge.
  task automatic step(input logic rst, input logic iv, input logic sa,
                      input logic [7:0] a, input logic [7:0] b, input logic ordy);
    logic acc, xf;
    rst_ = rst; in_valid = iv; sel_a = sa; data_a = a; data_b = b; out_ready = ordy;
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
    end else begin
      acc = iv && (exp_q.size() < 2);
      xf  = (exp_q.size() > 0) && ordy;
      if (xf) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(sa ? a : b);
    end
    #1;
    check_state();
  endtask

  initial begin
    rst_ = 1'b0; in_valid = 1'b0; sel_a = 1'b0;
    data_a = '0; data_b = '0; out_ready = 1'b0;

    // Reset held two edges with a request pending.
    step(0, 1, 1, 8'h11, 8'h22, 0);
    step(0, 1, 1, 8'h11, 8'h22, 0);
    chk("reset_out", {24'd0, out}, 32'h0);
    // First edge after release accepts.
    step(1, 1, 1, 8'h77, 8'h00, 1);
    chk("first_accept", {24'd0, out}, 32'h77);
    step(1, 0, 0, 8'h00, 8'h00, 1);

    // Select truth.
    step(1, 1, 1, 8'hFF, 8'h00, 1);
    chk("sel_a_1", {24'd0, out}, 32'hFF);
    step(1, 1, 0, 8'hFF, 8'h00, 1);
    chk("sel_a_0", {24'd0, out}, 32'h00);
    step(1, 0, 0, 8'h00, 8'h00, 1);

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 1, 8'(i), 8'hEE, 1);
      chk("stream_out", {24'd0, out}, i);
    end
    step(1, 0, 0, 8'h00, 8'h00, 1);

    // Back-pressure fill, refused third offer, then drain.
    step(1, 1, 1, 8'hA5, 8'h00, 0);
    step(1, 1, 0, 8'h00, 8'h5A, 0);
    chk("bp_level", {30'd0, level}, 32'd2);
    chk("bp_head", {24'd0, out}, 32'hA5);
    step(1, 1, 1, 8'h99, 8'h99, 0);
    chk("bp_refused", {30'd0, level}, 32'd2);
    step(1, 0, 0, 8'h00, 8'h00, 1);
    chk("bp_drain1", {24'd0, out}, 32'h5A);
    step(1, 0, 0, 8'h00, 8'h00, 1);
    chk("bp_empty", {30'd0, level}, 32'd0);

    // Inputs change after capture while stalled.
    step(1, 1, 1, 8'h3C, 8'h00, 0);
    step(1, 0, 0, 8'hC3, 8'h00, 0);
    step(1, 0, 1'bx, 8'hxx, 8'hxx, 0);
    chk("hold_3c", {24'd0, out}, 32'h3C);
    step(1, 0, 0, 8'h00, 8'h00, 1);

    // Reset while FULL drops both words.
    step(1, 1, 1, 8'h01, 8'h00, 0);
    step(1, 1, 1, 8'h02, 8'h00, 0);
    step(0, 0, 0, 8'h00, 8'h00, 0);
    chk("midrst_level", {30'd0, level}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    step(1, 1, 0, 8'h00, 8'h6B, 1);
    chk("midrst_first", {24'd0, out}, 32'h6B);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h00, 8'h00, 1);
    chk("final_empty", {30'd0, level}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
